// File: rtl/soc_dbg_pkg.sv
// Shared definitions for the debug register bank.
// Word offsets, CTRL bit indices, read FSM states, byte-lane merge helper.
package soc_dbg_pkg;

  localparam logic [5:0] W_CTRL   = 6'h00;
  localparam logic [5:0] W_LED    = 6'h01;
  localparam logic [5:0] W_CYCLE  = 6'h02;
  localparam logic [5:0] W_STATUS = 6'h03;
  localparam logic [5:0] W_DEBUG  = 6'h04;
  localparam logic [5:0] W_DUTY   = 6'h10;

  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_SNAP   = 1;

  localparam int DUTY_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_e;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? din[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/soc_dbg_pwm.sv
// Vectorised LED PWM: one shared 8-bit counter, per-channel duty compare.
// Only instantiated when SOC_DBG_PWM_EN is defined.
module soc_dbg_pwm
  import soc_dbg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N*DUTY_W-1:0] duty_i,
  output logic [N-1:0]        pwm_o
);

  logic [DUTY_W-1:0] cnt_q;
  logic [DUTY_W-1:0] cnt_d;

  assign cnt_d = cnt_q + DUTY_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    pwm_o = '0;
    for (int j = 0; j < N; j++)
      pwm_o[j] = cnt_q < duty_i[j*DUTY_W +: DUTY_W];
  end

endmodule

// File: rtl/soc_dbg_bank.sv
// CPU-mapped debug register bank: LEDs, cycle counter, frozen debug channels.
// Optional LED PWM duty registers when SOC_DBG_PWM_EN is defined.
module soc_dbg_bank
  import soc_dbg_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DW   = 32,
  parameter int NLED = 4
) (
  input  logic              XCLK,
  input  logic              XRES,
  input  logic [7:0]        XADDR,
  input  logic [31:0]       XDATI,
  output logic [31:0]       XDATO,
  input  logic [3:0]        XBE,
  input  logic              XWR,
  input  logic              XRD,
  output logic              XHLT,
  output logic [NLED-1:0]   LED,
  output logic [NCH*DW-1:0] DEBUG
);

  logic [DW-1:0]   live_q [NCH];
  logic [DW-1:0]   live_d [NCH];
  logic [DW-1:0]   shad_q [NCH];
  logic [DW-1:0]   shad_d [NCH];
  logic [NLED-1:0] led_q, led_d;
  logic            frz_q, frz_d;
  logic [7:0]      snap_q, snap_d;
  logic [31:0]     cyc_q;
  logic [31:0]     rdat_q, rdat_d;
  logic [31:0]     rv;
  rd_state_e       st_q, st_d;

  logic [5:0] word;
  logic       rd;
  logic       hit_ctrl, hit_led, hit_cyc, hit_stat, hit_dbg;
  logic       unused_addr;

  assign word        = XADDR[7:2];
  assign unused_addr = ^XADDR[1:0];
  assign rd          = XRD & ~XWR;
  assign hit_ctrl    = word == W_CTRL;
  assign hit_led     = word == W_LED;
  assign hit_cyc     = word == W_CYCLE;
  assign hit_stat    = word == W_STATUS;
  assign hit_dbg     = (word >= W_DEBUG) &&
                       (word < W_DEBUG + 6'(NCH));

`ifdef SOC_DBG_PWM_EN
  logic [DUTY_W-1:0]      duty_q [NLED];
  logic [DUTY_W-1:0]      duty_d [NLED];
  logic [NLED*DUTY_W-1:0] duty_flat;
  logic [NLED-1:0]        pwm;
  logic                   hit_duty;

  assign hit_duty = (word >= W_DUTY) &&
                    (word < W_DUTY + 6'(NLED));

  always_comb begin
    duty_flat = '0;
    for (int j = 0; j < NLED; j++)
      duty_flat[j*DUTY_W +: DUTY_W] = duty_q[j];
  end

  soc_dbg_pwm #(.N(NLED)) u_pwm (
    .clk_i  (XCLK),
    .rst_i  (XRES),
    .duty_i (duty_flat),
    .pwm_o  (pwm)
  );

  assign LED = led_q & pwm;
`else
  assign LED = led_q;
`endif

  // Register writes; a SNAP write copies the pre-edge live bank.
  always_comb begin
    live_d = live_q;
    shad_d = shad_q;
    led_d  = led_q;
    frz_d  = frz_q;
    snap_d = snap_q;
`ifdef SOC_DBG_PWM_EN
    duty_d = duty_q;
`endif
    if (XWR) begin
      unique case (1'b1)
        hit_ctrl: begin
          frz_d = XDATI[CTRL_FREEZE];
          if (XDATI[CTRL_SNAP]) begin
            shad_d = live_q;
            snap_d = snap_q + 8'd1;
          end
        end
        hit_led:
          led_d = NLED'(be_merge(32'(led_q), XDATI, XBE));
        hit_dbg:
          for (int i = 0; i < NCH; i++)
            if (word == W_DEBUG + 6'(i))
              live_d[i] = DW'(be_merge(32'(live_q[i]), XDATI, XBE));
`ifdef SOC_DBG_PWM_EN
        hit_duty:
          for (int j = 0; j < NLED; j++)
            if (word == W_DUTY + 6'(j) && XBE[0])
              duty_d[j] = XDATI[DUTY_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rv = '0;
    unique case (1'b1)
      hit_ctrl: rv[CTRL_FREEZE] = frz_q;
      hit_led:  rv = 32'(led_q);
      hit_cyc:  rv = cyc_q;
      hit_stat: rv = {16'h0, snap_q, 7'h0, frz_q};
      hit_dbg:
        for (int i = 0; i < NCH; i++)
          if (word == W_DEBUG + 6'(i)) rv = 32'(live_q[i]);
`ifdef SOC_DBG_PWM_EN
      hit_duty:
        for (int j = 0; j < NLED; j++)
          if (word == W_DUTY + 6'(j)) rv = 32'(duty_q[j]);
`endif
      default: ;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    rdat_d = rdat_q;
    unique case (st_q)
      ST_IDLE:
        if (rd) begin
          st_d   = ST_ACK;
          rdat_d = rv;
        end
      ST_ACK:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  assign XHLT  = (st_q == ST_IDLE) & rd & ~XRES;
  assign XDATO = (st_q == ST_ACK && !XRES) ? rdat_q : 32'h0;

  for (genvar g = 0; g < NCH; g++) begin : g_dbg
    assign DEBUG[g*DW +: DW] = frz_q ? shad_q[g] : live_q[g];
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      for (int i = 0; i < NCH; i++) begin
        live_q[i] <= '0;
        shad_q[i] <= '0;
      end
      led_q  <= '0;
      frz_q  <= 1'b0;
      snap_q <= '0;
      cyc_q  <= '0;
      rdat_q <= '0;
      st_q   <= ST_IDLE;
    end else begin
      live_q <= live_d;
      shad_q <= shad_d;
      led_q  <= led_d;
      frz_q  <= frz_d;
      snap_q <= snap_d;
      cyc_q  <= cyc_q + 32'd1;
      rdat_q <= rdat_d;
      st_q   <= st_d;
    end
  end

`ifdef SOC_DBG_PWM_EN
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      for (int j = 0; j < NLED; j++)
        duty_q[j] <= 8'hFF;
    end else begin
      duty_q <= duty_d;
    end
  end
`endif

endmodule

// File: tb/tb_soc_dbg_bank.sv
// Randomised and directed bench for soc_dbg_bank against a behavioural model.
// Exercises PWM expectations too when SOC_DBG_PWM_EN is defined.
module tb_soc_dbg_bank;

  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int NLED = 4;
`ifdef SOC_DBG_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              XRES = 1'b1;
  logic [7:0]        XADDR = '0;
  logic [31:0]       XDATI = '0;
  logic [31:0]       XDATO;
  logic [3:0]        XBE = '0;
  logic              XWR = 1'b0;
  logic              XRD = 1'b0;
  logic              XHLT;
  logic [NLED-1:0]   LED;
  logic [NCH*DW-1:0] DEBUG;

  int nchk = 0;
  int nerr = 0;

  soc_dbg_bank #(.NCH(NCH), .DW(DW), .NLED(NLED)) dut (
    .XCLK(clk), .XRES(XRES), .XADDR(XADDR), .XDATI(XDATI),
    .XDATO(XDATO), .XBE(XBE), .XWR(XWR), .XRD(XRD),
    .XHLT(XHLT), .LED(LED), .DEBUG(DEBUG)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_live [NCH];
  logic [31:0] m_shad [NCH];
  logic [7:0]  m_duty [NLED];
  logic [31:0] m_led = '0;
  logic        m_frz = 1'b0;
  logic [7:0]  m_snap = '0;
  logic [31:0] m_cyc = '0;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdat = '0;
  bit          m_on = 1'b0;

  function automatic logic [31:0] bemask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] wmask(input int w);
    longint one = 1;
    return 32'((one << w) - 1);
  endfunction

  function automatic logic [31:0] mread(input int w);
    if (w == 0) return {31'h0, m_frz};
    if (w == 1) return m_led;
    if (w == 2) return m_cyc;
    if (w == 3) return {16'h0, m_snap, 7'h0, m_frz};
    if (w >= 4 && w < 4 + NCH) return m_live[w-4];
    if (PWM && w >= 16 && w < 16 + NLED) return {24'h0, m_duty[w-16]};
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    int w;
    logic [31:0] bm;
    w = int'(XADDR[7:2]);
    bm = bemask(XBE);
    if (XRES) begin
      for (int i = 0; i < NCH; i++) begin
        m_live[i] = '0;
        m_shad[i] = '0;
      end
      for (int j = 0; j < NLED; j++) m_duty[j] = 8'hFF;
      m_led = '0; m_frz = 0; m_snap = '0; m_cyc = '0; m_ack = 0;
      m_on = 1'b1;
    end else begin
      if (m_ack) m_ack = 1'b0;
      else if (XRD && !XWR) begin
        m_ack = 1'b1;
        m_rdat = mread(w);
      end
      if (XWR) begin
        if (w == 0) begin
          if (XDATI[1]) begin
            for (int i = 0; i < NCH; i++) m_shad[i] = m_live[i];
            m_snap = m_snap + 8'd1;
          end
          m_frz = XDATI[0];
        end else if (w == 1) begin
          m_led = ((m_led & ~bm) | (XDATI & bm)) & wmask(NLED);
        end else if (w >= 4 && w < 4 + NCH) begin
          m_live[w-4] = ((m_live[w-4] & ~bm) | (XDATI & bm)) & wmask(DW);
        end else if (PWM && w >= 16 && w < 16 + NLED && XBE[0]) begin
          m_duty[w-16] = XDATI[7:0];
        end
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NLED-1:0] el;
    logic [31:0] ed;
    if (m_on) begin
      chk("XHLT", 32'(XHLT), 32'(!m_ack && XRD && !XWR && !XRES));
      chk("XDATO", XDATO, (m_ack && !XRES) ? m_rdat : 32'h0);
      for (int j = 0; j < NLED; j++)
        el[j] = m_led[j] & (PWM ? (m_cyc[7:0] < m_duty[j]) : 1'b1);
      chk("LED", 32'(LED), 32'(el));
      for (int i = 0; i < NCH; i++) begin
        ed = m_frz ? m_shad[i] : m_live[i];
        chk("DEBUG", 32'(DEBUG[i*DW +: DW]), ed);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    XADDR = a; XDATI = d; XBE = be; XWR = 1'b1; XRD = 1'b0;
    tick();
    XWR = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    XADDR = a; XRD = 1'b1; XWR = 1'b0;
    @(negedge clk);
    chk("rd_wait", 32'(XHLT), 32'h1);
    tick();
    XRD = 1'b0;
    @(negedge clk);
    chk("ack_nowait", 32'(XHLT), 32'h0);
    d = XDATO;
    tick();
  endtask

  task automatic at_neg_chk(input string nm, input logic [31:0] act_sel,
                            input logic [31:0] exp);
    chk(nm, act_sel, exp);
  endtask

  logic [31:0] v1, v2, v;
  int c0, c1, r, wsel;

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_dato", XDATO, 32'h0);
    chk("rst_hlt", 32'(XHLT), 32'h0);
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_dbg0", DEBUG[31:0], 32'h0);
    tick();
    XRES = 1'b0;

    rd(8'h08, v1);
    chk("cyc_first", v1, 32'd0);
    repeat (8) tick();
    rd(8'h08, v2);
    chk("cyc_delta", v2 - v1, 32'd10);

    wr(8'h04, 32'hFFFF_FFFF, 4'b0001);
    wr(8'h04, 32'h0000_0000, 4'b0000);
    rd(8'h04, v);
    chk("led_reg", v, 32'h0000_000F);

    wr(8'h10, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    chk("dbg0_be", DEBUG[31:0], 32'h0000_BEEF);
    tick();
    rd(8'h10, v);
    chk("rd_dbg0", v, 32'h0000_BEEF);

    wr(8'h14, 32'd5, 4'hF);
    wr(8'h00, 32'h3, 4'hF);
    wr(8'h14, 32'd9, 4'hF);
    @(negedge clk);
    chk("frozen_out", DEBUG[63:32], 32'd5);
    tick();
    rd(8'h14, v);
    chk("rd_live", v, 32'd9);
    rd(8'h0C, v);
    chk("status1", v, 32'h0000_0101);
    wr(8'h00, 32'h2, 4'hF);
    @(negedge clk);
    chk("unfrz_out", DEBUG[63:32], 32'd9);
    tick();
    rd(8'h0C, v);
    chk("status2", v, 32'h0000_0200);

    repeat (254) wr(8'h00, 32'h2, 4'hF);
    rd(8'h0C, v);
    chk("snap_wrap", v, 32'h0000_0000);

    rd(8'h3C, v);
    chk("unmapped_rd", v, 32'h0);
    wr(8'h3C, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk("unmapped_wr0", DEBUG[31:0], 32'h0000_BEEF);
    chk("unmapped_wr1", DEBUG[63:32], 32'd9);
    tick();

    XADDR = 8'h04; XDATI = 32'h5; XBE = 4'h1; XWR = 1'b1; XRD = 1'b1;
    @(negedge clk);
    chk("both_nowait", 32'(XHLT), 32'h0);
    tick();
    XWR = 1'b0; XRD = 1'b0;
    @(negedge clk);
    chk("both_noack", XDATO, 32'h0);
    tick();
    rd(8'h04, v);
    chk("both_wrote", v, 32'h5);

    if (PWM) begin
      wr(8'h04, 32'hF, 4'h1);
      wr(8'h40, 32'h40, 4'h1);
      c0 = 0; c1 = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        c0 += int'(LED[0]);
        c1 += int'(LED[1]);
      end
      tick();
      chk("pwm_duty40", 32'(c0), 32'd64);
      chk("pwm_dutyFF", 32'(c1), 32'd255);
    end

    XADDR = 8'h08; XRD = 1'b1;
    tick();
    XRD = 1'b0; XRES = 1'b1;
    @(negedge clk);
    chk("abort_hlt", 32'(XHLT), 32'h0);
    chk("abort_dato", XDATO, 32'h0);
    tick();
    XRES = 1'b0;
    @(negedge clk);
    chk("post_rst_hlt", 32'(XHLT), 32'h0);
    chk("post_rst_dato", XDATO, 32'h0);
    tick();
    rd(8'h08, v);
    chk("post_rst_cyc", v, 32'd1);

    for (int n = 0; n < 4000; n++) begin
      XWR = 1'b0; XRD = 1'b0; XRES = 1'b0;
      r = $urandom_range(0, 15);
      wsel = $urandom_range(0, 21);
      XADDR = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                          : {6'(wsel), 2'($urandom)};
      XDATI = $urandom;
      XBE = 4'($urandom);
      if (r < 4) XWR = 1'b1;
      else if (r < 8) XRD = 1'b1;
      else if (r == 8) begin XWR = 1'b1; XRD = 1'b1; end
      if ($urandom_range(0, 299) == 0) XRES = 1'b1;
      tick();
    end
    XWR = 1'b0; XRD = 1'b0; XRES = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
